// File: rtl/cd_fifo_sector_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cd_fifo_sector_ctrl
// Description : Sequences one CD-ROM sector through a 16-byte data FIFO.
//               The FIFO is filled from the disc decoder byte stream in
//               chunks of up to CHUNK_BYTES. Its read side is then shared
//               between the CPU byte port and the DMA halfword port, with
//               the CPU given priority. This block owns all FIFO strobes
//               (we / re_8 / re_16 / clr), and at most one of them is high
//               in any cycle.
// Ports       : clk, rst            clock, asynchronous active-high reset
//               i_start / i_abort   begin / drop a sector transfer
//               i_src_*/o_src_ready decoder byte stream handshake
//               i_cpu_rd_req, o_cpu_rd_ack, o_cpu_rd_data   CPU byte port
//               i_dma_rd_req, o_dma_rd_ack, o_dma_rd_data   DMA halfword port
//               o_fifo_*, i_fifo_data_out, i_fifo_full      FIFO control
//               o_busy, o_data_ready, o_sector_done         status
// Revision    : 1.0 - initial release
// ============================================================================
module cd_fifo_sector_ctrl #(
    parameter int SECTOR_BYTES = 2048,
    parameter int CHUNK_BYTES  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_src_valid,
    input  logic [7:0]  i_src_data,
    output logic        o_src_ready,
    input  logic        i_cpu_rd_req,
    output logic        o_cpu_rd_ack,
    output logic [7:0]  o_cpu_rd_data,
    input  logic        i_dma_rd_req,
    output logic        o_dma_rd_ack,
    output logic [15:0] o_dma_rd_data,
    output logic        o_fifo_we,
    output logic        o_fifo_re_8,
    output logic        o_fifo_re_16,
    output logic        o_fifo_clr,
    output logic [7:0]  o_fifo_data_in,
    input  logic [15:0] i_fifo_data_out,
    input  logic        i_fifo_full,
    output logic        o_busy,
    output logic        o_data_ready,
    output logic        o_sector_done
);

    localparam int BL_W = $clog2(SECTOR_BYTES + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FILL  = 2'd1;
    localparam logic [1:0] c_READY = 2'd2;
    localparam logic [1:0] c_CLEAR = 2'd3;

    localparam logic [4:0]      c_CHUNK  = 5'(CHUNK_BYTES);
    localparam logic [BL_W-1:0] c_SECTOR = BL_W'(SECTOR_BYTES);

    // The counters are 5 bits wide, and the tail logic relies on even
    // chunk and sector sizes. Any other size is rejected when the design
    // is elaborated.
    generate
        if ((SECTOR_BYTES < 2) || (SECTOR_BYTES > 4095) || ((SECTOR_BYTES % 2) != 0) ||
            (CHUNK_BYTES < 2) || (CHUNK_BYTES > 16) || ((CHUNK_BYTES % 2) != 0)) begin : g_bad_params
            $error("cd_fifo_sector_ctrl: illegal SECTOR_BYTES / CHUNK_BYTES");
        end
    endgenerate

    logic [1:0]      r_state;
    logic [4:0]      r_wr_cnt;
    logic [4:0]      r_rd_cnt;
    logic [BL_W-1:0] r_bytes_left;
    logic            r_sector_done;

    logic [1:0]      w_nxt_state;
    logic [4:0]      w_nxt_wr_cnt;
    logic [4:0]      w_nxt_rd_cnt;
    logic [BL_W-1:0] w_nxt_bytes_left;
    logic            w_nxt_done;
    logic [4:0]      w_avail;
    logic            w_src_ready;
    logic            w_we;
    logic            w_re_8;
    logic            w_re_16;
    logic            w_clr;
    logic            w_cpu_ack;
    logic            w_dma_ack;
    logic            w_last_pop;

    // Bytes written into the current chunk and not yet read. The FIFO's
    // own empty flag is ignored; these counts decide every read.
    assign w_avail = r_wr_cnt - r_rd_cnt;

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_wr_cnt     = r_wr_cnt;
        w_nxt_rd_cnt     = r_rd_cnt;
        w_nxt_bytes_left = r_bytes_left;
        w_nxt_done       = 1'b0;
        w_src_ready      = 1'b0;
        w_we             = 1'b0;
        w_re_8           = 1'b0;
        w_re_16          = 1'b0;
        w_clr            = 1'b0;
        w_cpu_ack        = 1'b0;
        w_dma_ack        = 1'b0;
        w_last_pop       = 1'b0;

        if ((r_state != c_IDLE) && i_abort) begin
            // Abort overrides every other action. It drops the chunk and
            // returns to IDLE without signalling completion.
            w_clr        = 1'b1;
            w_nxt_wr_cnt = 5'd0;
            w_nxt_rd_cnt = 5'd0;
            w_nxt_state  = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // An abort in the same cycle cancels the start.
                    if (i_start && !i_abort) begin
                        w_clr            = 1'b1;
                        w_nxt_bytes_left = c_SECTOR;
                        w_nxt_wr_cnt     = 5'd0;
                        w_nxt_rd_cnt     = 5'd0;
                        w_nxt_state      = c_FILL;
                    end
                end
                c_FILL: begin
                    w_src_ready = 1'b1;
                    if (i_src_valid) begin
                        w_we             = 1'b1;
                        w_nxt_wr_cnt     = r_wr_cnt + 5'd1;
                        w_nxt_bytes_left = r_bytes_left - BL_W'(1);
                        // The chunk closes on its last slot, or on the
                        // sector's final byte for the short tail chunk.
                        if (((r_wr_cnt + 5'd1) == c_CHUNK) || (r_bytes_left == BL_W'(1))) begin
                            w_nxt_state = c_READY;
                        end
                    end
                end
                c_READY: begin
                    if (i_cpu_rd_req && (w_avail != 5'd0)) begin
                        w_cpu_ack    = 1'b1;
                        w_re_8       = 1'b1;
                        w_nxt_rd_cnt = r_rd_cnt + 5'd1;
                        w_last_pop   = (w_avail == 5'd1);
                    end else if (i_dma_rd_req && (w_avail >= 5'd2)) begin
                        // A lone odd byte is never served to DMA. The CPU
                        // must drain it first.
                        w_dma_ack    = 1'b1;
                        w_re_16      = 1'b1;
                        w_nxt_rd_cnt = r_rd_cnt + 5'd2;
                        w_last_pop   = (w_avail == 5'd2);
                    end
                    if (w_last_pop) begin
                        if (r_bytes_left != '0) begin
                            w_nxt_state = c_CLEAR;
                        end else begin
                            w_nxt_done  = 1'b1;
                            w_nxt_state = c_IDLE;
                        end
                    end
                end
                c_CLEAR: begin
                    w_clr        = 1'b1;
                    w_nxt_wr_cnt = 5'd0;
                    w_nxt_rd_cnt = 5'd0;
                    w_nxt_state  = c_FILL;
                end
                default: begin
                    w_nxt_state = c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_wr_cnt      <= 5'd0;
            r_rd_cnt      <= 5'd0;
            r_bytes_left  <= '0;
            r_sector_done <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_wr_cnt      <= w_nxt_wr_cnt;
            r_rd_cnt      <= w_nxt_rd_cnt;
            r_bytes_left  <= w_nxt_bytes_left;
            r_sector_done <= w_nxt_done;
        end
    end

    assign o_src_ready    = w_src_ready;
    assign o_fifo_we      = w_we;
    assign o_fifo_re_8    = w_re_8;
    assign o_fifo_re_16   = w_re_16;
    assign o_fifo_clr     = w_clr;
    assign o_fifo_data_in = i_src_data;
    assign o_cpu_rd_ack   = w_cpu_ack;
    assign o_dma_rd_ack   = w_dma_ack;
    // The FIFO head is presented with zero latency in the ack cycle. The
    // read data is held at zero when there is no ack.
    assign o_cpu_rd_data  = w_cpu_ack ? i_fifo_data_out[7:0] : 8'd0;
    assign o_dma_rd_data  = w_dma_ack ? i_fifo_data_out      : 16'd0;
    assign o_busy         = (r_state != c_IDLE);
    assign o_data_ready   = (r_state == c_READY) && (w_avail != 5'd0);
    assign o_sector_done  = r_sector_done;

    // During FILL the FIFO holds fewer than CHUNK_BYTES entries. A full
    // flag here means the FIFO and the controller have lost step.
    a_no_full_in_fill: assert property (@(posedge clk) disable iff (rst)
        !((r_state == c_FILL) && i_fifo_full && (r_wr_cnt < c_CHUNK)));

endmodule
`default_nettype wire

// File: tb/tb_cd_fifo_sector_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cd_fifo_sector_ctrl
// Description : Scoreboard testbench for cd_fifo_sector_ctrl. It drives a
//               32-byte instance and a 2340-byte instance, each attached to
//               its own 16-byte FIFO model. The expected read stream is the
//               accepted source byte order, and chunk boundaries are
//               derived from the byte index.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cd_fifo_sector_ctrl;

    localparam int N_DUT = 2;
    localparam int SEC_A = 32;
    localparam int SEC_B = 2340;
    localparam int CHUNK = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start     [N_DUT];
    logic        abrt      [N_DUT];
    logic        src_valid [N_DUT];
    logic [7:0]  src_data  [N_DUT];
    logic        src_ready [N_DUT];
    logic        cpu_req   [N_DUT];
    logic        cpu_ack   [N_DUT];
    logic [7:0]  cpu_data  [N_DUT];
    logic        dma_req   [N_DUT];
    logic        dma_ack   [N_DUT];
    logic [15:0] dma_data  [N_DUT];
    logic        f_we      [N_DUT];
    logic        f_re8     [N_DUT];
    logic        f_re16    [N_DUT];
    logic        f_clr     [N_DUT];
    logic [7:0]  f_din     [N_DUT];
    logic [15:0] f_dout    [N_DUT];
    logic        f_full    [N_DUT];
    logic        busy      [N_DUT];
    logic        drdy      [N_DUT];
    logic        sdone     [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int SB = (g == 0) ? SEC_A : SEC_B;
        logic [7:0] mem [16];
        logic [3:0] wp;
        logic [3:0] rp;
        logic [4:0] cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp <= 4'd0; rp <= 4'd0; cnt <= 5'd0;
            end else if (f_clr[g]) begin
                wp <= 4'd0; rp <= 4'd0; cnt <= 5'd0;
            end else if (f_we[g]) begin
                mem[wp] <= f_din[g]; wp <= wp + 4'd1; cnt <= cnt + 5'd1;
            end else if (f_re8[g]) begin
                rp <= rp + 4'd1; cnt <= cnt - 5'd1;
            end else if (f_re16[g]) begin
                rp <= rp + 4'd2; cnt <= cnt - 5'd2;
            end
        end
        assign f_dout[g] = {mem[rp + 4'd1], mem[rp]};
        assign f_full[g] = (cnt == 5'd16);

        cd_fifo_sector_ctrl #(.SECTOR_BYTES(SB), .CHUNK_BYTES(CHUNK)) u_dut (
            .clk(clk), .rst(rst),
            .i_start(start[g]), .i_abort(abrt[g]),
            .i_src_valid(src_valid[g]), .i_src_data(src_data[g]), .o_src_ready(src_ready[g]),
            .i_cpu_rd_req(cpu_req[g]), .o_cpu_rd_ack(cpu_ack[g]), .o_cpu_rd_data(cpu_data[g]),
            .i_dma_rd_req(dma_req[g]), .o_dma_rd_ack(dma_ack[g]), .o_dma_rd_data(dma_data[g]),
            .o_fifo_we(f_we[g]), .o_fifo_re_8(f_re8[g]), .o_fifo_re_16(f_re16[g]),
            .o_fifo_clr(f_clr[g]), .o_fifo_data_in(f_din[g]),
            .i_fifo_data_out(f_dout[g]), .i_fifo_full(f_full[g]),
            .o_busy(busy[g]), .o_data_ready(drdy[g]), .o_sector_done(sdone[g])
        );
    end

    int         total = 0;
    int         bad   = 0;
    int         cur   = 0;
    int         sec_len = SEC_A;
    logic [7:0] sec_bytes [$];
    logic [7:0] exp_q [$];
    int         wi = 0;
    int         rdx = 0;
    int         we_cnt = 0;
    int         clr_cnt = 0;
    int         done_cnt = 0;
    bit         done_due = 1'b0;
    bit         mon_en = 1'b0;

    task automatic check_eq(input string name, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [33:0] outs(input int k);
        return {src_ready[k], cpu_ack[k], cpu_data[k], dma_ack[k], dma_data[k],
                f_we[k], f_re8[k], f_re16[k], f_clr[k], busy[k], drdy[k], sdone[k]};
    endfunction

    // A chunk ends at the next multiple of CHUNK, or at the end of the sector.
    function automatic int chunk_end(input int r);
        int e;
        e = (r / CHUNK + 1) * CHUNK;
        return (e > sec_len) ? sec_len : e;
    endfunction

    // Monitor: samples each cycle away from the clock edge and pops the
    // scoreboard whenever the DUT presents an ack.
    task automatic monitor_cycle();
        int k;
        int o;
        int ce;
        logic [7:0] b0;
        logic [7:0] b1;
        bit last;
        k = cur;
        o = 1 - cur;
        last = 1'b0;
        check_eq("other_quiet", outs(o), '0);
        check_eq("strobe_onehot", 34'($countones({f_we[k], f_re8[k], f_re16[k], f_clr[k]}) <= 1), 34'd1);
        check_eq("ack_exclusive", 34'(cpu_ack[k] & dma_ack[k]), 34'd0);
        if (f_we[k])  we_cnt++;
        if (f_clr[k]) clr_cnt++;
        ce = chunk_end(rdx);
        if (cpu_ack[k]) begin
            check_eq("cpu_chunk_complete", 34'(wi >= ce), 34'd1);
            check_eq("cpu_data_avail", 34'(exp_q.size() >= 1), 34'd1);
            if (exp_q.size() >= 1) begin
                b0 = exp_q.pop_front();
                check_eq("cpu_rd_data", 34'(cpu_data[k]), 34'(b0));
            end
            rdx += 1;
            last = (rdx == sec_len);
        end
        if (dma_ack[k]) begin
            check_eq("dma_cpu_priority", 34'(cpu_req[k]), 34'd0);
            check_eq("dma_two_in_chunk", 34'((ce - rdx) >= 2), 34'd1);
            check_eq("dma_chunk_complete", 34'(wi >= ce), 34'd1);
            check_eq("dma_data_avail", 34'(exp_q.size() >= 2), 34'd1);
            if (exp_q.size() >= 2) begin
                b0 = exp_q.pop_front();
                b1 = exp_q.pop_front();
                check_eq("dma_rd_data", 34'(dma_data[k]), 34'({b1, b0}));
            end
            rdx += 2;
            last = (rdx == sec_len);
        end
        check_eq("sector_done", 34'(sdone[k]), 34'(done_due));
        if (sdone[k]) done_cnt++;
        done_due = last;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) monitor_cycle();
        end
    end

    // Drives one cycle of random stimulus. It is called at a negedge, and
    // accepted source bytes go to the scoreboard.
    task automatic drive_cycle(input int vprob, input int cprob, input int dprob);
        start[cur]     = 1'b0;
        abrt[cur]      = 1'b0;
        src_valid[cur] = (wi < sec_len) && ($urandom_range(99) < vprob);
        src_data[cur]  = (wi < sec_len) ? sec_bytes[wi] : 8'($urandom);
        cpu_req[cur]   = ($urandom_range(99) < cprob);
        dma_req[cur]   = ($urandom_range(99) < dprob);
        #1;
        if (src_valid[cur] && src_ready[cur]) begin
            exp_q.push_back(sec_bytes[wi]);
            wi++;
        end
    endtask

    task automatic idle_inputs(input int k);
        start[k] = 1'b0; abrt[k] = 1'b0; src_valid[k] = 1'b0;
        src_data[k] = 8'd0; cpu_req[k] = 1'b0; dma_req[k] = 1'b0;
    endtask

    task automatic begin_sector(input int k, input int mode);
        cur = k;
        sec_len = (k == 0) ? SEC_A : SEC_B;
        sec_bytes.delete();
        for (int i = 0; i < sec_len; i++)
            sec_bytes.push_back((mode == 0) ? 8'(i) : 8'($urandom));
        exp_q.delete();
        wi = 0; rdx = 0; we_cnt = 0; clr_cnt = 0; done_cnt = 0; done_due = 1'b0;
        @(negedge clk);
        idle_inputs(k);
        start[k] = 1'b1;
        #1;
        check_eq("start_clr", 34'(f_clr[k]), 34'd1);
    endtask

    task automatic run_until_done(input int vprob, input int cprob, input int dprob, input int budget);
        int n;
        n = 0;
        while ((done_cnt == 0) && (n < budget)) begin
            @(negedge clk);
            drive_cycle(vprob, cprob, dprob);
            n++;
        end
        idle_inputs(cur);
        check_eq("sector_finished", 34'(done_cnt > 0), 34'd1);
    endtask

    task automatic end_sector_checks();
        @(negedge clk);
        #3;
        check_eq("total_popped", 34'(rdx), 34'(sec_len));
        check_eq("total_written", 34'(we_cnt), 34'(sec_len));
        check_eq("scoreboard_empty", 34'(exp_q.size()), 34'd0);
        check_eq("clr_pulses", 34'(clr_cnt), 34'((sec_len + CHUNK - 1) / CHUNK));
        check_eq("done_once", 34'(done_cnt), 34'd1);
        check_eq("idle_after", 34'(busy[cur]), 34'd0);
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!drdy[cur] && (n < budget)) begin
            @(negedge clk);
            drive_cycle(100, 0, 0);
            n++;
        end
        check_eq("fill_reaches_ready", 34'(drdy[cur]), 34'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int we_before;
        for (int k = 0; k < N_DUT; k++) idle_inputs(k);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outs_a", outs(0), '0);
        check_eq("reset_outs_b", outs(1), '0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: 32-byte sector with incrementing data and DMA reads only.
        begin_sector(0, 0);
        run_until_done(100, 0, 100, 2000);
        end_sector_checks();

        // Tests 2 and 3: arbitration, and a DMA request held off on a lone byte.
        begin_sector(0, 0);
        wait_ready(200);
        @(negedge clk);
        src_valid[0] = 1'b0; cpu_req[0] = 1'b1; dma_req[0] = 1'b1;
        #1;
        check_eq("t2_cpu_first", 34'({cpu_ack[0], dma_ack[0]}), 34'b10);
        check_eq("t2_cpu_byte", 34'(cpu_data[0]), 34'h00);
        @(negedge clk);
        cpu_req[0] = 1'b0;
        #1;
        check_eq("t2_dma_next", 34'({cpu_ack[0], dma_ack[0]}), 34'b01);
        check_eq("t2_dma_word", 34'(dma_data[0]), 34'h0201);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cpu_req[0] = 1'b1; dma_req[0] = 1'b0;
            #1;
            check_eq("t3_cpu_ack", 34'(cpu_ack[0]), 34'd1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_req[0] = 1'b0; dma_req[0] = 1'b1;
            #1;
            check_eq("t3_dma_held", 34'({dma_ack[0], drdy[0]}), 34'b01);
        end
        @(negedge clk);
        cpu_req[0] = 1'b1;
        #1;
        check_eq("t3_cpu_last", 34'({cpu_ack[0], dma_ack[0], cpu_data[0]}), 34'({2'b10, 8'h0F}));
        @(negedge clk);
        cpu_req[0] = 1'b0; dma_req[0] = 1'b0;
        #1;
        check_eq("t3_clear", 34'({busy[0], drdy[0], f_clr[0]}), 34'b101);
        run_until_done(100, 50, 50, 2000);
        end_sector_checks();

        // Test 4: raw-mode sector, 146 full chunks plus a 4-byte tail.
        begin_sector(1, 1);
        run_until_done(80, 40, 60, 40000);
        end_sector_checks();

        // Test 5: abort during FILL after 5 bytes, then a fresh sector.
        begin_sector(0, 1);
        n = 0;
        while ((wi < 5) && (n < 100)) begin
            @(negedge clk);
            drive_cycle(100, 0, 0);
            n++;
        end
        @(negedge clk);
        idle_inputs(0);
        abrt[0] = 1'b1;
        #1;
        check_eq("t5_abort", 34'({f_clr[0], f_we[0], src_ready[0]}), 34'b100);
        @(negedge clk);
        abrt[0] = 1'b0;
        #1;
        check_eq("t5_idle", 34'({busy[0], drdy[0]}), 34'b00);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_eq("t5_no_done", 34'(done_cnt), 34'd0);
        begin_sector(0, 1);
        run_until_done(70, 60, 60, 3000);
        end_sector_checks();

        // Test 6: source gaps, start while busy, async reset mid-READY.
        begin_sector(0, 1);
        repeat (6) begin
            @(negedge clk);
            drive_cycle(50, 0, 0);
        end
        @(negedge clk);
        src_valid[0] = 1'b0;
        start[0] = 1'b1;
        #1;
        check_eq("t6_start_ignored", 34'({f_clr[0], busy[0]}), 34'b01);
        wait_ready(200);
        repeat (3) begin
            @(negedge clk);
            drive_cycle(0, 100, 0);
        end
        @(negedge clk);
        idle_inputs(0);
        we_before = wi;
        #3;
        rst = 1'b1;
        #1;
        check_eq("t6_async_rst", outs(0), '0);
        check_eq("t6_no_extra_we", 34'(we_cnt), 34'(we_before));
        exp_q.delete();
        wi = 0; rdx = 0; done_due = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("t6_post_rst", outs(0), '0);
        begin_sector(0, 1);
        run_until_done(50, 50, 50, 3000);
        end_sector_checks();

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
